// File: rtl/updown_mod_counter.sv
// Up/down modulo-N counter with parallel load, optional saturation and
// carry/borrow pulses for cascading. Counts 0..MODULUS-1.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             c,
  input  logic             d,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow
);

  // Extended width so limit compares and +/-1 never wrap silently.
  localparam int unsigned CW = WIDTH + 1;
  localparam logic [CW-1:0] MAX_EXT = CW'(MODULUS - 1);
  localparam logic [CW-1:0] ONE_EXT = CW'(1);

  // Reject a modulus the count register cannot represent.
  if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  mode_e            mode_c;
  logic [CW-1:0]    cnt_ext_c;
  logic [CW-1:0]    load_ext_c;
  logic             at_max_c;
  logic             at_zero_c;

  // Decode the per-edge operation; load beats counting, opposing requests cancel.
  always_comb begin
    mode_c = MODE_HOLD;
    if (load) begin
      mode_c = MODE_LOAD;
    end else if (c && !d) begin
      mode_c = MODE_UP;
    end else if (d && !c) begin
      mode_c = MODE_DOWN;
    end
  end

  // Limit detection on the extended-width count.
  always_comb begin
    cnt_ext_c  = {1'b0, out_q};
    load_ext_c = {1'b0, load_val};
    at_max_c   = (cnt_ext_c >= MAX_EXT);
    at_zero_c  = (out_q == '0);
  end

  // Next count and carry/borrow pulses.
  always_comb begin
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    unique case (mode_c)
      MODE_LOAD: begin
        if (load_ext_c > MAX_EXT) begin
          out_d = MAX_EXT[WIDTH-1:0];
        end else begin
          out_d = load_val;
        end
      end
      MODE_UP: begin
        if (at_max_c) begin
          carry_d = 1'b1;
          out_d   = SATURATE ? out_q : '0;
        end else begin
          out_d = WIDTH'(cnt_ext_c + ONE_EXT);
        end
      end
      MODE_DOWN: begin
        if (at_zero_c) begin
          borrow_d = 1'b1;
          out_d    = SATURATE ? out_q : MAX_EXT[WIDTH-1:0];
        end else begin
          out_d = WIDTH'(cnt_ext_c - ONE_EXT);
        end
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  // State register; synchronous reset dominates everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign out    = out_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule
